// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver and the decoded byte/status out of it.
interface uart_rx_if;
    logic       rx;
    logic [7:0] dout;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input dout, valid, parity_err, frame_err, busy);
    modport slave  (input rx, output dout, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8E1 UART receiver: 2-flop synchronised line, mid-bit sampling, one-cycle valid with
// sticky dout/parity_err/frame_err that only change when valid pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [7:0]    shift_q, dout_q;
    logic          perr_pend_q, valid_q, perr_q, ferr_q, busy_q;
    logic          rx_fall_d, bit_tick_d;

    always_comb begin
        rx_fall_d  = rx_prev_q & ~rx_s_q;
        bit_tick_d = (cnt_q == LAST);
    end

    // Synchroniser plus one extra stage for falling-edge detection; all reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            unique case (state_q)
                IDLE: begin
                    if (rx_fall_d) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick_d) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick_d) begin
                        cnt_q       <= '0;
                        perr_pend_q <= (^shift_q) != rx_s_q;
                        state_q     <= STOP;
                    end
                end
                STOP: begin
                    // Results land together with valid, so IDLE is already live in the valid cycle.
                    if (bit_tick_d) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        dout_q  <= shift_q;
                        perr_q  <= perr_pend_q;
                        ferr_q  <= ~rx_s_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a sample-point model over the synchronised line checks every
// cycle, and per-frame literal expectations pin the model's latency and decoded values.
module tb_uart_rx;
    localparam int N    = 16;
    localparam int H    = N / 2;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_rx_if bus ();
    uart_rx #(.CLKS_PER_BIT(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Line history: value seen by the receiver after its 2-flop synchroniser, per clock edge.
    bit s_hist   [0:MAXC-1];
    bit rst_hist [0:MAXC-1];
    logic sm = 1'b1, ss = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            sm <= 1'b1;
            ss <= 1'b1;
            if (cyc + 1 < MAXC) s_hist[cyc + 1] <= 1'b1;
        end else begin
            sm <= bus.rx;
            ss <= sm;
            if (cyc + 1 < MAXC) s_hist[cyc + 1] <= sm;
        end
        if (cyc + 1 < MAXC) rst_hist[cyc + 1] <= !rst_n;
    end

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } vrec_t;
    vrec_t vq[$];

    bit         started = 1'b0;
    bit         m_frame = 1'b0;
    int         mE = 0;
    logic [7:0] m_bits = '0;
    logic       m_pbit = 1'b0, m_stop = 1'b1;
    logic       m_valid = 1'b0, m_busy = 1'b0, m_pe = 1'b0, m_fe = 1'b0;
    logic [7:0] m_dout = '0;

    always @(negedge clk) begin
        int  j;
        int  k;
        bit  was_idle;
        j = cyc;
        if (j > 0 && j < MAXC) begin
            if (rst_hist[j]) begin
                started = 1'b1;
                m_frame = 1'b0;
                m_dout  = '0;
                m_pe    = 1'b0;
                m_fe    = 1'b0;
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end else if (started) begin
                m_valid = 1'b0;
                if (m_frame && j == mE + H + 10 * N + 1) begin
                    m_valid = 1'b1;
                    m_dout  = m_bits;
                    m_pe    = ((^m_bits) != m_pbit);
                    m_fe    = !m_stop;
                    m_frame = 1'b0;
                end
                was_idle = !m_frame;
                m_busy   = m_frame && (j > mE);
                if (m_frame && j >= mE + H && ((j - mE - H) % N) == 0) begin
                    k = (j - mE - H) / N;
                    if (k == 0) begin
                        if (s_hist[j]) m_frame = 1'b0;
                    end else if (k <= 8) begin
                        m_bits[k - 1] = s_hist[j];
                    end else if (k == 9) begin
                        m_pbit = s_hist[j];
                    end else if (k == 10) begin
                        m_stop = s_hist[j];
                    end
                end
                if (was_idle && s_hist[j - 1] && !s_hist[j]) begin
                    m_frame = 1'b1;
                    mE      = j;
                end
            end
            if (started) begin
                n_cmp++;
                if (bus.valid !== m_valid || bus.busy !== m_busy || bus.dout !== m_dout ||
                    bus.parity_err !== m_pe || bus.frame_err !== m_fe) begin
                    n_bad++;
                    $display("FAIL cycle_%0d: got valid=%b busy=%b dout=%h pe=%b fe=%b, want valid=%b busy=%b dout=%h pe=%b fe=%b",
                             j, bus.valid, bus.busy, bus.dout, bus.parity_err, bus.frame_err,
                             m_valid, m_busy, m_dout, m_pe, m_fe);
                end
                if (bus.valid === 1'b1)
                    vq.push_back('{cyc: j, d: bus.dout, pe: bus.parity_err, fe: bus.frame_err});
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (N) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic st, output int t0);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(st);
    endtask

    // Valid must appear 170 edges after the first low line edge: 1 sync + H + 10 bits + 1.
    task automatic expect_frame(input string nm, input int t0, input logic [7:0] d,
                                input logic pe, input logic fe, output int vc);
        vrec_t r;
        vc = -1;
        if (vq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_missing: got no valid pulse, want one", nm);
        end else begin
            r  = vq.pop_front();
            vc = r.cyc;
            check({nm, "_latency"}, r.cyc - t0, 170);
            check({nm, "_dout"}, {24'd0, r.d}, {24'd0, d});
            check({nm, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
            check({nm, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, want end before time limit");
        $fatal(1);
    end

    initial begin
        int t0, t1, vc0, vc1;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("reset_dout",  {24'd0, bus.dout}, 32'h0);
        check("reset_valid", {31'd0, bus.valid}, 32'h0);
        check("reset_busy",  {31'd0, bus.busy}, 32'h0);
        check("reset_perr",  {31'd0, bus.parity_err}, 32'h0);
        check("reset_ferr",  {31'd0, bus.frame_err}, 32'h0);

        send_frame(8'hA5, 1'b0, 1'b1, t0);
        idle(20);
        expect_frame("clean_a5", t0, 8'hA5, 1'b0, 1'b0, vc0);
        check("clean_busy_after", {31'd0, bus.busy}, 32'h0);

        send_frame(8'h3C, 1'b1, 1'b1, t0);
        idle(20);
        expect_frame("parity_3c", t0, 8'h3C, 1'b1, 1'b0, vc0);

        send_frame(8'h81, 1'b0, 1'b0, t0);
        idle(20);
        expect_frame("frame_81", t0, 8'h81, 1'b0, 1'b1, vc0);
        send_frame(8'h55, 1'b0, 1'b1, t0);
        idle(20);
        expect_frame("clean_55", t0, 8'h55, 1'b0, 1'b0, vc0);

        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_no_valid", vq.size(), 0);
        check("glitch_dout_kept", {24'd0, bus.dout}, 32'h55);
        check("glitch_busy", {31'd0, bus.busy}, 32'h0);

        send_frame(8'h12, 1'b0, 1'b1, t0);
        send_frame(8'hEF, 1'b1, 1'b1, t1);
        idle(20);
        expect_frame("b2b_12", t0, 8'h12, 1'b0, 1'b0, vc0);
        expect_frame("b2b_ef", t1, 8'hEF, 1'b0, 1'b0, vc1);
        check("b2b_spacing", vc1 - vc0, 176);

        t0 = cyc + 1;
        bus.rx = 1'b0;
        repeat (15 * N) @(negedge clk);
        idle(30);
        expect_frame("break", t0, 8'h00, 1'b0, 1'b1, vc0);
        check("break_single_valid", vq.size(), 0);

        fork
            send_frame(8'hF0, 1'b1, 1'b1, t0);
            begin
                repeat (88) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(20);
        check("abort_no_valid", vq.size(), 0);
        check("abort_dout", {24'd0, bus.dout}, 32'h0);
        check("abort_ferr", {31'd0, bus.frame_err}, 32'h0);
        send_frame(8'h7E, 1'b0, 1'b1, t0);
        idle(20);
        expect_frame("after_abort_7e", t0, 8'h7E, 1'b0, 1'b0, vc0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per UART bit period; legal range 4..65535.
REQ-002 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous to clk, active-low.
REQ-004 Port: rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 Port: dout  output  8  last received data byte.
REQ-006 Port: valid  output  1  one-cycle pulse; a frame has completed.
REQ-007 Port: parity_err  output  1  parity mismatch on the last frame.
REQ-008 Port: frame_err  output  1  stop bit sampled low on the last frame.
REQ-009 Port: busy  output  1  high while a frame is being received.

Function
REQ-010 Frame format SHALL be: start (0), 8 data bits LSB first, parity bit, stop (1); parity bit = XOR of the 8 data bits (even parity).
REQ-011 rx SHALL pass through a 2-flop synchronizer; rx_s denotes its output; all decisions use rx_s only.
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP; the bit-period counter and 3-bit bit index are sized for CLKS_PER_BIT.
REQ-013 IDLE: on rx_s falling edge (prior 1, current 0), go to START, clear counter; this is cycle E. busy is high from cycle E+1 until the cycle valid asserts.
REQ-014 H = floor(CLKS_PER_BIT/2); sample points SHALL be: start at E+H, data bit i (0..7) at E+H+(i+1)*CLKS_PER_BIT, parity at E+H+9*CLKS_PER_BIT, stop at E+H+10*CLKS_PER_BIT.
REQ-015 START: if rx_s=1 at its sample point, false start; return to IDLE with no valid and outputs unchanged.
REQ-016 DATA: sampled bits SHALL shift into an internal register at index i; after bit 7 go to PARITY.
REQ-017 PARITY: parity_err is computed as (XOR of data) != sampled parity bit and held internally until STOP.
REQ-018 STOP: at the stop sample point, frame_err = ~rx_s; on the next cycle SHALL assert valid=1 for exactly one cycle, update dout, parity_err and frame_err together, and return to IDLE.
REQ-019 dout, parity_err and frame_err SHALL hold their values until the next valid pulse; they do not change on a false start or on an aborted frame.
REQ-020 A frame with errors SHALL still produce valid, with dout carrying the sampled bits.
REQ-021 In IDLE, a falling edge SHALL be detected in the same cycle that valid is high, so back-to-back frames with one stop bit are received without loss.
REQ-022 A line held low (break) SHALL produce one frame with dout=0x00 and frame_err=1; a new start SHALL be detected only after rx_s returns high and then falls again.
REQ-023 No stimulus SHALL cause valid to assert more than once per detected start edge.

Reset
REQ-024 While rst_n=0 at a clk edge: state=IDLE, counter=0, bit index=0, synchronizer flops=1, dout=0x00, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid pulse; after release the block waits for a new falling edge and does not resume the old frame.
REQ-026 The first frame after reset release SHALL be received correctly if its start edge arrives at least 3 cycles after release.

Verification (CLKS_PER_BIT=16)
REQ-027 Clean frame: rx drives 0xA5, parity 0, stop 1 -> one valid pulse at E+H+10*16+1; dout=0xA5, parity_err=0, frame_err=0; busy low afterwards.
REQ-028 Parity error: 0x3C with parity bit 1 -> valid; dout=0x3C, parity_err=1, frame_err=0.
REQ-029 Framing error: 0x81, parity 0, stop bit 0 -> valid; dout=0x81, frame_err=1; a subsequent clean 0x55 frame -> frame_err=0.
REQ-030 Glitch: rx low for 4 cycles, then high -> no valid; dout and flags keep their previous values; busy returns low by E+H+1.
REQ-031 Back-to-back: 0x12 then 0xEF with one stop bit and no idle gap -> two valid pulses 11*16 cycles apart; dout=0x12 and then 0xEF, no errors.
REQ-032 Reset mid-frame: rst_n low for 2 cycles during data bit 4 -> no valid; all outputs are 0; a following 0x7E frame is received correctly.
